// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared declarations for the reconstructing divider checker.
//   recon_state_t : controller states (IDLE, BUSY, DONE)
//   DIV_WIDTH     : default operand width
//   RADIX_BITS    : quotient bits retired per BUSY cycle
//   busy_cycles() : number of BUSY cycles for a given operand width
// Build option: define DIV_RECON_RADIX4_EN to retire two quotient bits per
// step instead of one.
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } recon_state_t;

  localparam int DIV_WIDTH = 30;

`ifdef DIV_RECON_RADIX4_EN
  localparam int RADIX_BITS = 2;
`else
  localparam int RADIX_BITS = 1;
`endif

  // An odd width in radix-4 mode rounds up: the quotient is zero-extended.
  function automatic int busy_cycles(input int width);
    return (width + RADIX_BITS - 1) / RADIX_BITS;
  endfunction

endpackage

// File: rtl/div_reconstruct_step.sv
// ---------------------------------------------------------------------------
// recon_step
// One combinational multiply-accumulate step of the numerator rebuild.
//   acc      : running accumulator (starts at the remainder)
//   dvs      : divisor already shifted to the weight of the current bits
//   dvs3     : 3x shifted divisor (radix-4 build only)
//   q_bits   : quotient bit(s) being retired this step
//   acc_next : accumulator after adding q_bits * dvs
// Build option: DIV_RECON_RADIX4_EN selects the two-bit step.
// ---------------------------------------------------------------------------
module recon_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH:0]      acc,
  input  logic [2*WIDTH:0]      dvs,
`ifdef DIV_RECON_RADIX4_EN
  input  logic [2*WIDTH:0]      dvs3,
`endif
  input  logic [RADIX_BITS-1:0] q_bits,
  output logic [2*WIDTH:0]      acc_next
);

  // The accumulator is wide enough for q*d + r, so the sum never wraps.
  always_comb begin
    acc_next = acc;
`ifdef DIV_RECON_RADIX4_EN
    case (q_bits)
      2'd1:    acc_next = acc + dvs;
      2'd2:    acc_next = acc + (dvs << 1);
      2'd3:    acc_next = acc + dvs3;
      default: acc_next = acc;
    endcase
`else
    if (q_bits[0]) begin
      acc_next = acc + dvs;
    end
`endif
  end

endmodule

// File: rtl/div_reconstruct.sv
// ---------------------------------------------------------------------------
// div_reconstruct
// Rebuilds numerator = quotient*divisor + remainder with a fixed-latency
// shift-and-add loop and flags remainders that are not below the divisor.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   in_valid   : operand set offered        in_ready  : accepting (IDLE)
//   quotient, divisor, remainder : WIDTH-bit unsigned operands
//   out_valid  : result held (DONE)          out_ready : consumer takes it
//   numerator  : 2*WIDTH+1 bit reconstructed numerator
//   rem_err    : remainder >= divisor for the accepted set
// Build option: DIV_RECON_RADIX4_EN retires two quotient bits per cycle
// (ceil(WIDTH/2) BUSY cycles); otherwise one bit per cycle (WIDTH cycles).
// ---------------------------------------------------------------------------
module div_reconstruct
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   remainder,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH:0]   numerator,
  output logic               rem_err
);

  localparam int ACC_W = 2*WIDTH + 1;
  localparam int STEPS = busy_cycles(WIDTH);
  localparam int QW    = STEPS * RADIX_BITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (WIDTH < 4) begin : g_width_check
    $error("div_reconstruct: WIDTH must be at least 4");
  end

  recon_state_t     state;
  recon_state_t     state_next;
  logic [QW-1:0]    q_reg;
  logic [ACC_W-1:0] d_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic             err_reg;
  logic [CNT_W-1:0] step_cnt;
  logic             last_step;
`ifdef DIV_RECON_RADIX4_EN
  logic [ACC_W-1:0] d3_reg;
`endif

  assign last_step = (step_cnt == LAST_STEP);

  recon_step #(
    .WIDTH    (WIDTH)
  ) u_step (
    .acc      (acc_reg),
    .dvs      (d_reg),
`ifdef DIV_RECON_RADIX4_EN
    .dvs3     (d3_reg),
`endif
    .q_bits   (q_reg[RADIX_BITS-1:0]),
    .acc_next (acc_next)
  );

  // State register; reset always drops back to IDLE, abandoning any result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshakes come straight from the state, so a retiring cycle (DONE)
  // can never also accept operands.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operands are captured on accept and then only the shifting
  // copies are used, so later input changes cannot disturb the result.
  // Every BUSY cycle performs a step, including the one that enters DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg    <= '0;
      d_reg    <= '0;
      acc_reg  <= '0;
      err_reg  <= 1'b0;
      step_cnt <= '0;
`ifdef DIV_RECON_RADIX4_EN
      d3_reg   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg    <= QW'(quotient);
            d_reg    <= ACC_W'(divisor);
            acc_reg  <= ACC_W'(remainder);
            err_reg  <= (remainder >= divisor);
            step_cnt <= '0;
`ifdef DIV_RECON_RADIX4_EN
            d3_reg   <= ACC_W'(divisor) + (ACC_W'(divisor) << 1);
`endif
          end
        end
        BUSY: begin
          acc_reg <= acc_next;
          d_reg   <= d_reg << RADIX_BITS;
          q_reg   <= q_reg >> RADIX_BITS;
`ifdef DIV_RECON_RADIX4_EN
          d3_reg  <= d3_reg << 2;
`endif
          if (!last_step) begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign numerator = acc_reg;
  assign rem_err   = err_reg;

endmodule

// File: doc/div_reconstruct.md
DIV_RECONSTRUCT -- requirements
Module: div_reconstruct

Interface
REQ-001 Parameter: WIDTH, default 30, operand width in bits; SHALL be at least 4.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-004 Port: in_valid  input  1  operand set offered.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: quotient  input  WIDTH  unsigned quotient to verify.
REQ-007 Port: divisor  input  WIDTH  unsigned divisor.
REQ-008 Port: remainder  input  WIDTH  unsigned remainder.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: numerator  output  2*WIDTH+1  reconstructed numerator = quotient*divisor + remainder.
REQ-012 Port: rem_err  output  1  remainder >= divisor for the accepted operand set.

Function
REQ-013 FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 IDLE to BUSY: in_valid && in_ready. DONE to IDLE: out_valid && out_ready. No other transitions except reset.
REQ-015 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE; no operand is accepted in the cycle a result retires.
REQ-016 On accept, the block SHALL register quotient, divisor and remainder, initialise the accumulator to remainder, and register rem_err = (remainder >= divisor).
REQ-017 BUSY, radix-2 step: if the quotient LSB is 1, add the shifted divisor to the accumulator; shift the divisor left 1; shift the quotient right 1.
REQ-018 BUSY SHALL last exactly WIDTH cycles (fixed latency, no early exit). out_valid SHALL rise WIDTH edges after the accept edge.
REQ-019 Accumulator width SHALL be 2*WIDTH+1 bits, so the result never overflows.
REQ-020 numerator and rem_err SHALL be held stable throughout DONE. Input changes after accept SHALL have no effect.
REQ-021 divisor = 0: numerator SHALL equal remainder, and rem_err SHALL be 1.
REQ-022 quotient = 0: numerator SHALL equal remainder, with the full latency still applied.

Reset
REQ-023 While reset = 0: state SHALL be IDLE, out_valid = 0, numerator = 0, rem_err = 0, and all internal registers SHALL be cleared; in_ready SHALL read 1.
REQ-024 Reset asserted in BUSY or DONE SHALL abort the operation with no result emitted.
REQ-025 The first accept SHALL be possible on the first rising edge after reset releases.

Configuration
REQ-026 Macro DIV_RECON_RADIX4_EN defined: each BUSY step SHALL retire 2 quotient bits, adding 0, d, 2d or 3d (3d precomputed at accept). BUSY SHALL last ceil(WIDTH/2) cycles. Odd WIDTH SHALL be zero-extended.
REQ-027 Macro DIV_RECON_RADIX4_EN undefined: the radix-2 step of REQ-017 SHALL apply, with WIDTH-cycle latency. The port list SHALL be identical in both builds.

Structure
REQ-028 Shared package div_pkg SHALL hold the state typedef recon_state_t (IDLE, BUSY, DONE) and the default-width constant DIV_WIDTH = 30.
REQ-029 A combinational sub-module recon_step SHALL perform one step (accumulator, divisor, quotient-bit(s) in; updated accumulator out). The radix is selected by the same macro.
REQ-030 The step counter SHALL be $clog2(WIDTH+1) bits wide.

Verification
REQ-031 WIDTH=30, radix-2: q=7, d=5, r=3 -> numerator=38, rem_err=0, out_valid exactly 30 edges after accept.
REQ-032 q=2^30-1, d=2^30-1, r=2^30-2 -> numerator=2^60-2^30-1, rem_err=0, no truncation.
REQ-033 q=5, d=0, r=9 -> numerator=9, rem_err=1; then q=3, d=4, r=4 -> numerator=16, rem_err=1.
REQ-034 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> numerator stable, in_ready=0, nothing accepted. Then out_ready=1 -> IDLE, in_ready=1 on the next cycle.
REQ-035 Assert reset at BUSY cycle 12 -> out_valid=0, numerator=0, in_ready=1. A following q=7, d=5, r=3 -> 38.
REQ-036 DIV_RECON_RADIX4_EN defined: rerun REQ-031 and REQ-032 -> same results, with out_valid 15 edges after accept.
